cal: RTL and testbench



---
 rtl/cal_pkg.sv | 36 +++
 rtl/cal_div.sv | 85 ++++++++
 rtl/cal.sv | 148 ++++++++++++++
 tb/tb_cal.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared constants and magnitude helpers for the spectral gain calculator.
// Pure combinational functions; no state.
// Not applicable: no handshake lives here.
package cal_pkg;

    localparam int N      = 2048;          // bins per frame (power of two)
    localparam int DATA_W = 24;            // signed re/im width
    localparam int GAIN_W = 24;            // gain output width
    localparam int FRAC_W = 16;            // fractional bits of gain
    localparam int MAG_W  = DATA_W + 1;    // alpha-max-beta-min magnitude width

    // |v| with the single unrepresentable negative value clamped to +max.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
        if (v == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v[DATA_W-1])
            return DATA_W'(-v);
        else
            return DATA_W'(v);
    endfunction

    // max + 0.375*min, using two shifts so no multiplier is needed.
    function automatic logic [MAG_W-1:0] mag_approx(input logic signed [DATA_W-1:0] re,
                                                    input logic signed [DATA_W-1:0] im);
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] mx;
        logic [DATA_W-1:0] mn;
        a  = abs_sat(re);
        b  = abs_sat(im);
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return {1'b0, mx} + {3'b000, mn[DATA_W-1:2]} + {4'b0000, mn[DATA_W-1:3]};
    endfunction

endpackage

// File: rtl/cal_div.sv
// Sequential restoring unsigned divider, one quotient bit per cycle, saturating.
// Latency: Q_W cycles from accepted start to the done pulse (result registered with done).
// Backpressure: i_start is ignored while o_busy is high; the caller must hold the request.
module cal_div #(
    parameter int NUM_W = 41,
    parameter int DEN_W = 25,
    parameter int Q_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_q
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [Q_W-1:0]   r_sh;     // low numerator bits shift out, quotient bits shift in
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             r_busy;
    logic             r_done;
    logic [Q_W-1:0]   r_q;

    logic [NUM_W-1:0] w_hi;
    logic [NUM_W-1:0] w_den_ext;
    logic             w_sat;
    logic [DEN_W:0]   w_trial;
    logic             w_ge;
    logic [DEN_W-1:0] w_diff;

    // Quotient overflows Q_W bits exactly when num>>Q_W >= den; in that case the
    // upper bits already form a valid starting remainder (< den) otherwise.
    assign w_hi      = i_num >> Q_W;
    assign w_den_ext = NUM_W'(i_den);
    assign w_sat     = (i_den == '0) || (w_hi >= w_den_ext);

    // Remainder stays below den, so the difference always fits DEN_W bits.
    assign w_trial = {r_rem, r_sh[Q_W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_den});
    assign w_diff  = w_trial[DEN_W-1:0] - r_den;

    // Load on start, then one restore/subtract step per cycle until the count expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_sh   <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_q    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_rem  <= w_hi[DEN_W-1:0];
                r_den  <= i_den;
                r_sh   <= i_num[Q_W-1:0];
                r_sat  <= w_sat;
                r_cnt  <= CNT_W'(Q_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff : w_trial[DEN_W-1:0];
                r_sh  <= {r_sh[Q_W-2:0], w_ge};
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_q    <= r_sat ? '1 : {r_sh[Q_W-2:0], w_ge};
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_q    = r_q;

endmodule

// File: rtl/cal.sv
// Per-frame gain |Y|/|X| taken at the bin of peak |X| across two FFT output streams.
// Latency: calvalid/gain update GAIN_W+3 cycles after the edge accepting the last bin.
// Backpressure: none; always accepts bins, one-deep request queue in front of the divider.
module cal
    import cal_pkg::*;
#(
    parameter bit SKIP_DC = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x_re,
    input  logic signed [DATA_W-1:0] x_im,
    input  logic signed [DATA_W-1:0] y_re,
    input  logic signed [DATA_W-1:0] y_im,
    input  logic                     fft_out_valid,
    output logic [GAIN_W-1:0]        gain,
    output logic                     calvalid
);

    localparam int BIN_W = $clog2(N);
    localparam int NUM_W = MAG_W + FRAC_W;

    logic [BIN_W-1:0]  r_bin_cnt;
    logic              r_m_vld;
    logic              r_m_first;
    logic              r_m_last;
    logic [MAG_W-1:0]  r_m_x;
    logic [MAG_W-1:0]  r_m_y;
    logic [MAG_W-1:0]  r_pk_x;
    logic [MAG_W-1:0]  r_pk_y;
    logic              r_q_vld;
    logic [MAG_W-1:0]  r_q_x;
    logic [MAG_W-1:0]  r_q_y;
    logic [GAIN_W-1:0] r_gain;
    logic              r_calvalid;

    logic              w_first;
    logic              w_last;
    logic [MAG_W-1:0]  w_base_x;
    logic [MAG_W-1:0]  w_base_y;
    logic              w_use;
    logic              w_upd;
    logic [MAG_W-1:0]  w_nx;
    logic [MAG_W-1:0]  w_ny;
    logic              w_start;
    logic              w_busy;
    logic              w_done;
    logic [GAIN_W-1:0] w_q;

    assign w_first = (r_bin_cnt == '0);
    assign w_last  = (r_bin_cnt == BIN_W'(N - 1));

    // Bin counter advances only on accepted bins; gaps simply stall it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin_cnt <= '0;
        end else if (fft_out_valid) begin
            r_bin_cnt <= w_last ? '0 : r_bin_cnt + 1'b1;
        end
    end

    // Magnitude stage: register both magnitudes with the frame position tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_vld   <= 1'b0;
            r_m_first <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_x     <= '0;
            r_m_y     <= '0;
        end else begin
            r_m_vld <= fft_out_valid;
            if (fft_out_valid) begin
                r_m_first <= w_first;
                r_m_last  <= w_last;
                r_m_x     <= mag_approx(x_re, x_im);
                r_m_y     <= mag_approx(y_re, y_im);
            end
        end
    end

    // Peak candidate: bin 0 compares against a cleared peak so no stale frame leaks in.
    always_comb begin
        w_base_x = r_m_first ? '0 : r_pk_x;
        w_base_y = r_m_first ? '0 : r_pk_y;
        w_use    = r_m_vld && !(SKIP_DC && r_m_first);
        w_upd    = w_use && (r_m_x > w_base_x);
        w_nx     = w_upd ? r_m_x : w_base_x;
        w_ny     = w_upd ? r_m_y : w_base_y;
    end

    assign w_start = r_q_vld && !w_busy;

    // Track the peak; on the last bin hand the result to the queue and clear for the next frame.
    // A push while the queue is full overwrites the older request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pk_x  <= '0;
            r_pk_y  <= '0;
            r_q_vld <= 1'b0;
            r_q_x   <= '0;
            r_q_y   <= '0;
        end else begin
            if (r_m_vld) begin
                r_pk_x <= r_m_last ? '0 : w_nx;
                r_pk_y <= r_m_last ? '0 : w_ny;
            end
            if (r_m_vld && r_m_last) begin
                r_q_vld <= 1'b1;
                r_q_x   <= w_nx;
                r_q_y   <= w_ny;
            end else if (w_start) begin
                r_q_vld <= 1'b0;
            end
        end
    end

    cal_div #(
        .NUM_W (NUM_W),
        .DEN_W (MAG_W),
        .Q_W   (GAIN_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_num   ({r_q_y, {FRAC_W{1'b0}}}),
        .i_den   (r_q_x),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_q     (w_q)
    );

    // Output register: gain holds between results, calvalid is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain     <= '0;
            r_calvalid <= 1'b0;
        end else begin
            r_calvalid <= w_done;
            if (w_done) begin
                r_gain <= w_q;
            end
        end
    end

    assign gain     = r_gain;
    assign calvalid = r_calvalid;

endmodule

// File: tb/tb_cal.sv
// Bench for cal: frame-level stimulus, reference gain computed from the frame arrays.
// Checks value, latency, single pulse and hold for each frame.
// Drives with random and fixed gaps on fft_out_valid.
module tb_cal;

    localparam int NB  = 2048;
    localparam int GW  = 24;
    localparam int LAT = GW + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] x_re, x_im, y_re, y_im;
    logic               fft_out_valid;
    logic [23:0]        gain;
    logic               calvalid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int fxr[NB];
    int fxi[NB];
    int fyr[NB];
    int fyi[NB];

    logic [23:0] ev_gain[$];
    int          ev_cyc[$];
    int          acc_q[$];

    cal dut (
        .clk           (clk),
        .rst           (rst),
        .x_re          (x_re),
        .x_im          (x_im),
        .y_re          (y_re),
        .y_im          (y_im),
        .fft_out_valid (fft_out_valid),
        .gain          (gain),
        .calvalid      (calvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (calvalid === 1'b1) begin
            ev_gain.push_back(gain);
            ev_cyc.push_back(cyc);
        end
    end

    // Alpha-max-beta-min with beta = 1/4 + 1/8, full-scale negative clamped to +max.
    function automatic longint ref_mag(input int re, input int im);
        longint a, b, mx, mn;
        a = (re < 0) ? -longint'(re) : longint'(re);
        b = (im < 0) ? -longint'(im) : longint'(im);
        if (a > 8388607) a = 8388607;
        if (b > 8388607) b = 8388607;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    // Peak |X| over bins 1..N-1 (first wins ties), gain = |Y|*2^16/|X| saturating.
    function automatic logic [23:0] ref_gain();
        longint px, py, mx, q;
        px = 0;
        py = 0;
        for (int b = 1; b < NB; b++) begin
            mx = ref_mag(fxr[b], fxi[b]);
            if (mx > px) begin
                px = mx;
                py = ref_mag(fyr[b], fyi[b]);
            end
        end
        if (px == 0) return 24'hFFFFFF;
        q = (py * 65536) / px;
        if (q >= 64'd16777216) return 24'hFFFFFF;
        return q[23:0];
    endfunction

    function automatic int rnd_val();
        int v;
        v = $signed($urandom) >>> (8 + $urandom_range(20));
        if ($urandom_range(50) == 0) v = -8388608;
        return v;
    endfunction

    task automatic clear_frame();
        for (int b = 0; b < NB; b++) begin
            fxr[b] = 0; fxi[b] = 0; fyr[b] = 0; fyi[b] = 0;
        end
    endtask

    task automatic put(input int xr, input int xi, input int yr, input int yi, input logic v);
        x_re = 24'(xr);
        x_im = 24'(xi);
        y_re = 24'(yr);
        y_im = 24'(yi);
        fft_out_valid = v;
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: valid toggles every cycle, 2: random gaps.
    task automatic send_frame(input int mode, input int nbins);
        for (int b = 0; b < nbins; b++) begin
            if (mode == 1 && b > 0)
                put(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b0);
            if (mode == 2)
                while ($urandom_range(3) == 0)
                    put(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b0);
            put(fxr[b], fxi[b], fyr[b], fyi[b], 1'b1);
        end
        fft_out_valid = 1'b0;
        if (nbins == NB) acc_q.push_back(cyc);
    endtask

    task automatic check_frame(input string name, input logic [23:0] expg);
        int          waited;
        int          a;
        int          c;
        logic [23:0] g;
        waited = 0;
        a = (acc_q.size() > 0) ? acc_q.pop_front() : 0;
        while (ev_gain.size() == 0 && waited < LAT + 20) begin
            @(negedge clk); #1;
            waited++;
        end
        checks++;
        if (ev_gain.size() == 0) begin
            failures++;
            $display("FAIL %s_timeout: calvalid absent after %0d cycles, required one pulse", name, waited);
        end else begin
            g = ev_gain.pop_front();
            c = ev_cyc.pop_front();
            checks++;
            if (g !== expg) begin
                failures++;
                $display("FAIL %s_gain: got %h required %h", name, g, expg);
            end
            checks++;
            if (c - a != LAT) begin
                failures++;
                $display("FAIL %s_latency: got %0d required %0d", name, c - a, LAT);
            end
            repeat (6) @(negedge clk);
            #1;
            checks++;
            if (ev_gain.size() != 0) begin
                failures++;
                $display("FAIL %s_pulses: got %0d extra calvalid, required 0", name, ev_gain.size());
                ev_gain.delete();
                ev_cyc.delete();
            end
            checks++;
            if (gain !== expg) begin
                failures++;
                $display("FAIL %s_hold: got %h required %h", name, gain, expg);
            end
        end
    endtask

    task automatic load_tone();
        clear_frame();
        fxr[5] = 1000;
        fyr[5] = 2000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        x_re = '0; x_im = '0; y_re = '0; y_im = '0;
        fft_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (gain !== 24'h0) begin
            failures++;
            $display("FAIL reset_gain: got %h required 000000", gain);
        end
        checks++;
        if (calvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_calvalid: got %b required 0", calvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_tone();
        load_tone();
        send_frame(0, NB);
        check_frame("tone", 24'h020000);
    endtask

    task automatic test_mag_approx();
        clear_frame();
        fxi[7] = -1000;
        fyr[7] = 300;
        fyi[7] = 400;
        send_frame(0, NB);
        check_frame("mag", ref_gain());
    endtask

    task automatic test_dc_ties();
        clear_frame();
        fxr[0] = 5000;
        fxr[3] = 800;
        fxr[9] = 800;
        fyr[3] = 400;
        fyr[9] = 1600;
        send_frame(0, NB);
        check_frame("dc_ties", 24'h008000);
    endtask

    task automatic test_div_zero_ovf();
        clear_frame();
        send_frame(0, NB);
        check_frame("div_zero", 24'hFFFFFF);
        clear_frame();
        fxr[5] = 1;
        fyr[5] = 1000;
        send_frame(0, NB);
        check_frame("overflow", 24'hFFFFFF);
    endtask

    task automatic test_gapped();
        load_tone();
        send_frame(1, NB);
        check_frame("gapped_a", 24'h020000);
        repeat (3000) @(posedge clk);
        #1;
        send_frame(1, NB);
        check_frame("gapped_b", 24'h020000);
    endtask

    task automatic test_reset_mid_frame();
        clear_frame();
        fxr[500] = 4000000;
        fyr[500] = 1;
        ev_gain.delete(); ev_cyc.delete();
        send_frame(0, 1000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (gain !== 24'h0) begin
            failures++;
            $display("FAIL midframe_gain: got %h required 000000", gain);
        end
        checks++;
        if (calvalid !== 1'b0 || ev_gain.size() != 0) begin
            failures++;
            $display("FAIL midframe_calvalid: got %b (%0d pulses) required 0", calvalid, ev_gain.size());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        load_tone();
        send_frame(0, NB);
        check_frame("after_reset", 24'h020000);
    endtask

    task automatic test_reset_mid_div();
        clear_frame();
        fxr[20] = 3000;
        fyr[20] = 1000;
        send_frame(0, NB);
        acc_q.delete();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (LAT + 10) @(negedge clk);
        #1;
        checks++;
        if (ev_gain.size() != 0) begin
            failures++;
            $display("FAIL middiv_pulse: got %0d calvalid, required 0", ev_gain.size());
            ev_gain.delete(); ev_cyc.delete();
        end
        checks++;
        if (gain !== 24'h0) begin
            failures++;
            $display("FAIL middiv_gain: got %h required 000000", gain);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < NB; b++) begin
                fxr[b] = rnd_val(); fxi[b] = rnd_val();
                fyr[b] = rnd_val(); fyi[b] = rnd_val();
            end
            send_frame(2, NB);
            check_frame($sformatf("random%0d", f), ref_gain());
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] expg;
        int          a;
        int          c;
        logic [23:0] g;
        clear_frame();
        fxr[100] = 7000; fxi[100] = -2000;
        fyr[100] = -3000; fyi[100] = 6000;
        expg = ref_gain();
        send_frame(0, NB);
        send_frame(0, NB);
        repeat (LAT + 10) @(negedge clk);
        #1;
        checks++;
        if (ev_gain.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d calvalid required 2", ev_gain.size());
        end
        for (int k = 0; k < 2; k++) begin
            if (ev_gain.size() > 0 && acc_q.size() > 0) begin
                g = ev_gain.pop_front();
                c = ev_cyc.pop_front();
                a = acc_q.pop_front();
                checks++;
                if (g !== expg || c - a != LAT) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: got gain %h latency %0d required %h latency %0d",
                             k, g, c - a, expg, LAT);
                end
            end
        end
        ev_gain.delete(); ev_cyc.delete(); acc_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_mag_approx();
        test_dc_ties();
        test_div_zero_ovf();
        test_gapped();
        test_reset_mid_frame();
        test_reset_mid_div();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
